// File: rtl/tpm_fifo_xfer_if.sv
// Host-side LPC data-provider handshake for tpm_fifo_xfer; data stays a plain inout
// on the engine so the tristate sits on a real module port.
interface tpm_fifo_xfer_if;
  logic [15:0] addr;
  logic        data_wr;
  logic        wr_done;
  logic        data_req;
  logic        data_rd;

  modport master (output addr, data_wr, data_req, input wr_done, data_rd);
  modport slave  (input addr, data_wr, data_req, output wr_done, data_rd);
endinterface

// File: rtl/tpm_fifo_xfer.sv
// TPM FIFO-interface command/response engine (TPM_STS + TPM_DATA_FIFO, locality 0).
// Define TPM_FIFO_IRQ_EN to build the dataAvail interrupt; otherwise interrupt_o is tied 0.
module tpm_fifo_xfer #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned BURST_W = 16
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  inout  wire  [7:0]      data_io,
  tpm_fifo_xfer_if.slave  host,
  output logic            tpm_start_o,
  input  logic            tpm_cmd_rd_i,
  output logic [7:0]      tpm_cmd_o,
  output logic            tpm_cmd_empty_o,
  input  logic            tpm_rsp_wr_i,
  input  logic [7:0]      tpm_rsp_i,
  input  logic            tpm_rsp_done_i,
  output logic            interrupt_o
);
  localparam logic [15:0] AddrSts0 = 16'h0018;
  localparam logic [15:0] AddrSts1 = 16'h0019;
  localparam logic [15:0] AddrSts2 = 16'h001A;
  localparam logic [15:0] AddrSts3 = 16'h001B;
  localparam logic [15:0] AddrFifo = 16'h0024;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] DepthP = PW'(DEPTH);

  typedef enum logic [2:0] {StIdle, StReady, StReception, StExecution, StCompletion} state_e;

  state_e        state_q, state_d;
  logic          wr_done_q, req_q, data_rd_q, pop_pend_q, pop_pend_d, start_q, start_d;
  logic [7:0]    rd_data_q, rd_data_d, rd_val;
  logic [PW-1:0] wr_cnt_q, wr_cnt_d, cmd_ptr_q, cmd_ptr_d;
  logic [PW-1:0] rsp_cnt_q, rsp_cnt_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   size_q, size_d;
  logic [7:0]    mem [DEPTH];

  logic wr_fire, rd_rise, rd_fall, in_rx, expect_b, rsp_avail, cmd_avail;
  logic cmd_ready, go, fifo_wr, core_pop, core_push, host_pop;
  logic [BURST_W-1:0] burst;
  logic [7:0]         sts0;

  // Side effects fire once, on the first sampled cycle of each strobe.
  assign wr_fire   = host.data_wr & ~wr_done_q;
  assign rd_rise   = host.data_req & ~req_q;
  assign rd_fall   = ~host.data_req & req_q;
  assign in_rx     = (state_q == StReady) || (state_q == StReception);
  assign expect_b  = in_rx && ((wr_cnt_q < PW'(6)) || (32'(wr_cnt_q) < size_q));
  assign rsp_avail = (state_q == StCompletion) && (rd_ptr_q < rsp_cnt_q);
  assign cmd_avail = cmd_ptr_q < wr_cnt_q;

  assign cmd_ready = wr_fire && (host.addr == AddrSts0) && data_io[6];
  assign go        = wr_fire && (host.addr == AddrSts0) && data_io[5] && !data_io[6] &&
                     (state_q == StReception) && !expect_b;
  assign fifo_wr   = wr_fire && (host.addr == AddrFifo) && in_rx && (wr_cnt_q < DepthP);
  assign core_pop  = (state_q == StExecution) && tpm_cmd_rd_i && cmd_avail;
  assign core_push = (state_q == StExecution) && tpm_rsp_wr_i && (rsp_cnt_q < DepthP);
  assign host_pop  = rd_fall && pop_pend_q && rsp_avail;

  always_comb begin
    burst = '0;
    if (in_rx) begin
      burst = BURST_W'(DepthP - wr_cnt_q);
    end else if (state_q == StCompletion) begin
      burst = BURST_W'(rsp_cnt_q - rd_ptr_q);
    end
  end

  assign sts0 = {1'b1, state_q == StReady, 1'b0, rsp_avail, expect_b, 3'b000};

  always_comb begin
    rd_val = 8'hFF;
    case (host.addr)
      AddrSts0: rd_val = sts0;
      AddrSts1: rd_val = 8'(burst);
      AddrSts2: rd_val = 8'(burst >> 8);
      AddrSts3: rd_val = 8'h00;
      AddrFifo: if (rsp_avail) rd_val = mem[rd_ptr_q[AW-1:0]];
      default:  rd_val = 8'hFF;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (cmd_ready) begin
      state_d = StReady;
    end else begin
      case (state_q)
        StReady:     if (fifo_wr) state_d = StReception;
        StReception: if (go) state_d = StExecution;
        StExecution: if (tpm_rsp_done_i) state_d = StCompletion;
        default:     state_d = state_q;
      endcase
    end
  end

  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    cmd_ptr_d  = cmd_ptr_q;
    rsp_cnt_d  = rsp_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    size_d     = size_q;
    start_d    = go;
    rd_data_d  = rd_rise ? rd_val : rd_data_q;
    pop_pend_d = rd_rise ? ((host.addr == AddrFifo) && rsp_avail) : (pop_pend_q && !rd_fall);
    if (cmd_ready) begin
      wr_cnt_d  = '0;
      cmd_ptr_d = '0;
      rsp_cnt_d = '0;
      rd_ptr_d  = '0;
      size_d    = '0;
    end else begin
      if (fifo_wr) begin
        wr_cnt_d = wr_cnt_q + 1'b1;
        // Header bytes 2..5 carry the big-endian command size.
        if ((wr_cnt_q >= PW'(2)) && (wr_cnt_q <= PW'(5))) size_d = {size_q[23:0], data_io};
      end
      if (core_pop)  cmd_ptr_d = cmd_ptr_q + 1'b1;
      if (core_push) rsp_cnt_d = rsp_cnt_q + 1'b1;
      if (host_pop)  rd_ptr_d  = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      wr_done_q  <= 1'b0;
      req_q      <= 1'b0;
      data_rd_q  <= 1'b0;
      pop_pend_q <= 1'b0;
      start_q    <= 1'b0;
      rd_data_q  <= 8'h00;
      wr_cnt_q   <= '0;
      cmd_ptr_q  <= '0;
      rsp_cnt_q  <= '0;
      rd_ptr_q   <= '0;
      size_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_done_q  <= host.data_wr;
      req_q      <= host.data_req;
      data_rd_q  <= host.data_req;
      pop_pend_q <= pop_pend_d;
      start_q    <= start_d;
      rd_data_q  <= rd_data_d;
      wr_cnt_q   <= wr_cnt_d;
      cmd_ptr_q  <= cmd_ptr_d;
      rsp_cnt_q  <= rsp_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      size_q     <= size_d;
    end
  end

  // Shared buffer: command bytes in READY/RECEPTION, response bytes in EXECUTION.
  always_ff @(posedge clk_i) begin
    if (fifo_wr) begin
      mem[wr_cnt_q[AW-1:0]] <= data_io;
    end else if (core_push) begin
      mem[rsp_cnt_q[AW-1:0]] <= tpm_rsp_i;
    end
  end

`ifdef TPM_FIFO_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (cmd_ready) begin
      irq_d = 1'b0;
    end else if ((state_q == StExecution) && tpm_rsp_done_i && (rsp_cnt_d != '0)) begin
      irq_d = 1'b1;
    end else if (host_pop && (rd_ptr_d == rsp_cnt_q)) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign interrupt_o = irq_q;
`else
  assign interrupt_o = 1'b0;
`endif

  assign host.wr_done    = wr_done_q;
  assign host.data_rd    = data_rd_q;
  assign data_io         = (host.data_req && data_rd_q) ? rd_data_q : 8'hzz;
  assign tpm_start_o     = start_q;
  assign tpm_cmd_o       = cmd_avail ? mem[cmd_ptr_q[AW-1:0]] : 8'hFF;
  assign tpm_cmd_empty_o = ~cmd_avail;
endmodule

// File: tb/tb_tpm_fifo_xfer.sv
// Directed bench for tpm_fifo_xfer: host register vectors plus core-side lifecycle sequences.
module tb_tpm_fifo_xfer;
  localparam logic [15:0] Sts0  = 16'h0018;
  localparam logic [15:0] Sts1  = 16'h0019;
  localparam logic [15:0] Sts2  = 16'h001A;
  localparam logic [15:0] Sts3  = 16'h001B;
  localparam logic [15:0] Fifo  = 16'h0024;
  localparam logic [15:0] Other = 16'h0030;
`ifdef TPM_FIFO_IRQ_EN
  localparam logic [7:0] IrqOn = 8'h01;
`else
  localparam logic [7:0] IrqOn = 8'h00;
`endif

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wire  [7:0] data;
  logic [7:0] tb_data = 8'h00;
  logic tb_drv = 1'b0;
  logic tpm_start, cmd_rd = 1'b0, cmd_empty, rsp_wr = 1'b0, rsp_done = 1'b0, irq;
  logic [7:0] cmd_byte, rsp_byte = 8'h00;
  int n_tests = 0;
  int n_fail = 0;
  int start_cnt = 0;

  tpm_fifo_xfer_if hif ();

  assign data = tb_drv ? tb_data : 8'hzz;

  tpm_fifo_xfer #(.DEPTH(64), .BURST_W(16)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .data_io        (data),
    .host           (hif),
    .tpm_start_o    (tpm_start),
    .tpm_cmd_rd_i   (cmd_rd),
    .tpm_cmd_o      (cmd_byte),
    .tpm_cmd_empty_o(cmd_empty),
    .tpm_rsp_wr_i   (rsp_wr),
    .tpm_rsp_i      (rsp_byte),
    .tpm_rsp_done_i (rsp_done),
    .interrupt_o    (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tpm_start) start_cnt++;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [15:0] a, input logic [7:0] d);
    hif.addr = a;
    tb_data = d;
    tb_drv = 1'b1;
    hif.data_wr = 1'b1;
    @(negedge clk);
    check("wr_done_rise", 8'(hif.wr_done), 8'h01);
    hif.data_wr = 1'b0;
    tb_drv = 1'b0;
    @(negedge clk);
    check("wr_done_fall", 8'(hif.wr_done), 8'h00);
  endtask

  task automatic host_read(input string name, input logic [15:0] a, input int hold,
                           input logic [7:0] exp);
    hif.addr = a;
    hif.data_req = 1'b1;
    @(negedge clk);
    check("data_rd_rise", 8'(hif.data_rd), 8'h01);
    check(name, data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_held"}, data, exp);
    end
    hif.data_req = 1'b0;
    @(negedge clk);
    check("data_rd_fall", 8'(hif.data_rd), 8'h00);
  endtask

  initial begin
    vec_t vecs[25];
    logic [7:0] cmd[10];
    logic [7:0] rsp[4];

    vecs = '{
      '{0, Sts0,  8'h00, 8'h80}, '{0, Sts1,  8'h00, 8'h00}, '{1, Sts0,  8'h40, 8'h00},
      '{0, Sts0,  8'h00, 8'hC8}, '{0, Sts1,  8'h00, 8'h40}, '{0, Sts2,  8'h00, 8'h00},
      '{0, Sts3,  8'h00, 8'h00}, '{0, Other, 8'h00, 8'hFF}, '{1, Fifo,  8'h80, 8'h00},
      '{0, Sts0,  8'h00, 8'h88}, '{1, Fifo,  8'h01, 8'h00}, '{1, Fifo,  8'h00, 8'h00},
      '{1, Fifo,  8'h00, 8'h00}, '{1, Fifo,  8'h00, 8'h00}, '{1, Fifo,  8'h0A, 8'h00},
      '{1, Fifo,  8'h00, 8'h00}, '{1, Fifo,  8'h00, 8'h00}, '{1, Fifo,  8'h01, 8'h00},
      '{0, Sts0,  8'h00, 8'h88}, '{1, Fifo,  8'h44, 8'h00}, '{0, Sts0,  8'h00, 8'h80},
      '{0, Sts1,  8'h00, 8'h36}, '{0, Fifo,  8'h00, 8'hFF}, '{1, Other, 8'hAB, 8'h00},
      '{0, Sts1,  8'h00, 8'h36}
    };
    cmd = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h01, 8'h44};
    rsp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    hif.addr = 16'h0000;
    hif.data_wr = 1'b0;
    hif.data_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_done", 8'(hif.wr_done), 8'h00);
    check("rst_data_rd", 8'(hif.data_rd), 8'h00);
    check("rst_start", 8'(tpm_start), 8'h00);
    check("rst_empty", 8'(cmd_empty), 8'h01);
    check("rst_irq", 8'(irq), 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      if (vecs[i].is_wr) host_write(vecs[i].addr, vecs[i].data);
      else host_read($sformatf("vec%0d", i), vecs[i].addr, 0, vecs[i].exp);
    end

    // tpmGo, then the core drains the command.
    host_write(Sts0, 8'h20);
    @(negedge clk);
    check("start_pulses", 8'(start_cnt), 8'h01);
    host_read("exec_sts", Sts0, 0, 8'h80);
    host_read("exec_burst", Sts1, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("cmd_byte%0d", i), cmd_byte, cmd[i]);
      cmd_rd = 1'b1;
      @(negedge clk);
      cmd_rd = 1'b0;
    end
    check("cmd_drained", cmd_byte, 8'hFF);
    check("cmd_empty", 8'(cmd_empty), 8'h01);
    cmd_rd = 1'b1;
    @(negedge clk);
    cmd_rd = 1'b0;
    check("cmd_pop_empty", cmd_byte, 8'hFF);

    // Response push and host read-back.
    for (int i = 0; i < 4; i++) begin
      rsp_wr = 1'b1;
      rsp_byte = rsp[i];
      @(negedge clk);
    end
    rsp_wr = 1'b0;
    rsp_done = 1'b1;
    @(negedge clk);
    rsp_done = 1'b0;
    check("irq_set", 8'(irq), IrqOn);
    host_read("cpl_sts", Sts0, 0, 8'h90);
    host_read("cpl_burst", Sts1, 0, 8'h04);
    host_read("rsp0_hold", Fifo, 5, 8'hAA);
    host_read("burst_after_hold", Sts1, 0, 8'h03);
    host_read("rsp1", Fifo, 0, 8'hBB);
    host_read("rsp2", Fifo, 0, 8'hCC);
    check("irq_before_last", 8'(irq), IrqOn);
    host_read("rsp3", Fifo, 0, 8'hDD);
    check("irq_cleared", 8'(irq), 8'h00);
    host_read("drained_sts", Sts0, 0, 8'h80);
    host_read("rsp_extra", Fifo, 0, 8'hFF);
    host_read("drained_burst", Sts1, 0, 8'h00);

    // Oversized command: tpmGo refused, buffer fills and the overflow byte is dropped.
    host_write(Sts0, 8'h40);
    host_read("ready_again", Sts0, 0, 8'hC8);
    host_write(Fifo, 8'h80);
    host_write(Fifo, 8'h01);
    host_write(Fifo, 8'h00);
    host_write(Fifo, 8'h00);
    host_write(Fifo, 8'h01);
    host_write(Fifo, 8'h00);
    host_write(Sts0, 8'h20);
    @(negedge clk);
    check("big_go_ignored", 8'(start_cnt), 8'h01);
    host_read("big_sts", Sts0, 0, 8'h88);
    for (int i = 0; i < 59; i++) host_write(Fifo, 8'(i));
    host_read("full_burst_lo", Sts1, 0, 8'h00);
    host_write(Fifo, 8'h5A);
    host_read("over_burst_lo", Sts1, 0, 8'h00);
    host_read("over_burst_hi", Sts2, 0, 8'h00);
    host_read("over_sts", Sts0, 0, 8'h88);

    // commandReady during EXECUTION aborts and clears.
    host_write(Sts0, 8'h40);
    host_write(Fifo, 8'h80);
    host_write(Fifo, 8'h01);
    host_write(Fifo, 8'h00);
    host_write(Fifo, 8'h00);
    host_write(Fifo, 8'h00);
    host_write(Fifo, 8'h06);
    host_read("six_sts", Sts0, 0, 8'h80);
    host_write(Sts0, 8'h20);
    @(negedge clk);
    check("six_go", 8'(start_cnt), 8'h02);
    check("six_not_empty", 8'(cmd_empty), 8'h00);
    host_write(Sts0, 8'h40);
    check("abort_empty", 8'(cmd_empty), 8'h01);
    check("abort_cmd", cmd_byte, 8'hFF);
    host_read("abort_sts", Sts0, 0, 8'hC8);
    host_read("abort_burst", Sts1, 0, 8'h40);

    // Reset in the middle of reception.
    host_write(Fifo, 8'h11);
    host_write(Fifo, 8'h22);
    host_read("rx_burst", Sts1, 0, 8'h3E);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst2_empty", 8'(cmd_empty), 8'h01);
    check("rst2_irq", 8'(irq), 8'h00);
    host_read("rst2_sts", Sts0, 0, 8'h80);
    host_read("rst2_burst", Sts1, 0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
